// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: state encoding and bus-level constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_DATA  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives edge and START/STOP events.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_p_q, scl_p_d;
   logic                   sda_p_q, sda_p_d;

   // Shift chains plus one-cycle history of the synchronized levels.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_d    = scl_s;
      sda_p_d    = sda_s;
   end

   // Idle bus level is high, so every stage resets to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_p_q    <= scl_p_d;
         sda_p_q    <= sda_p_d;
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_p_q;
   assign scl_fall  = ~scl_s & scl_p_q;
   assign start_det = ~sda_s & sda_p_q & scl_s & scl_p_q;
   assign stop_det  = sda_s & ~sda_p_q & scl_s & scl_p_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte receive with ACK, byte transmit on read.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic       rw
);
   import i2c_pkg::*;

   logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d, nxt_bit;
   logic       full_q, full_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic       busy_q, busy_d, rw_q, rw_d, addr_hit;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_s     (scl_s),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign addr_hit = (shift_q[7:1] == SLAVE_ADDR);
   assign nxt_bit  = cnt_q - 3'd1;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; START/STOP win over everything else.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = ST_ADDR;
      end else if (stop_det) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     state_d = ST_IDLE;
            ST_ADDR:     if (scl_fall && full_q) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                         else state_d = ST_ADDR;
            ST_ADDR_ACK: if (scl_fall) state_d = (rw_q == RW_READ) ? ST_RD_DATA : ST_WR_DATA;
                         else state_d = ST_ADDR_ACK;
            ST_WR_DATA:  if (scl_fall && full_q) state_d = ST_WR_ACK;
                         else state_d = ST_WR_DATA;
            ST_WR_ACK:   if (scl_fall) state_d = ST_WR_DATA;
                         else state_d = ST_WR_ACK;
            ST_RD_DATA:  if (scl_fall && (cnt_q == 3'd0)) state_d = ST_RD_ACK;
                         else state_d = ST_RD_DATA;
            ST_RD_ACK:   if (scl_rise && (sda_s == NACK)) state_d = ST_IGNORE;
                         else if (scl_fall && full_q) state_d = ST_RD_DATA;
                         else state_d = ST_RD_ACK;
            ST_IGNORE:   state_d = ST_IGNORE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath and registered-output next values.
   always_comb begin
      cnt_d      = cnt_q;
      full_d     = full_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      if (start_det) begin
         cnt_d    = 3'd7;
         full_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else if (stop_det) begin
         full_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  if (cnt_q == 3'd0) full_d = 1'b1;
                  else cnt_d = nxt_bit;
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  cnt_d  = 3'd7;
                  if (state_q == ST_WR_DATA) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                  end else if (addr_hit) begin
                     rw_d     = shift_q[0];
                     busy_d   = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     busy_d   = 1'b0;
                     sda_oe_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_ADDR_ACK, ST_RD_ACK: begin
               if (state_q == ST_RD_ACK && scl_rise) begin
                  if (sda_s == NACK) busy_d = 1'b0;
                  else full_d = 1'b1;
               end else if (scl_fall && (state_q == ST_ADDR_ACK || full_q)) begin
                  cnt_d  = 3'd7;
                  full_d = 1'b0;
                  if (state_q == ST_ADDR_ACK && rw_q == RW_WRITE) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     // Load the next read byte and put its MSB on the bus.
                     shift_d  = tx_data;
                     tx_req_d = 1'b1;
                     sda_oe_d = ~tx_data[7];
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 3'd7;
                  full_d   = 1'b0;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd0) begin
                     sda_oe_d = 1'b0;
                     full_d   = 1'b0;
                  end else begin
                     cnt_d    = nxt_bit;
                     sda_oe_d = ~shift_q[nxt_bit];
                  end
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
      // SDA may only move while SCL is low, apart from START/STOP releasing it.
      if (scl_s && !start_det && !stop_det) begin
         sda_oe_d = sda_oe_q;
      end else begin
         sda_oe_d = sda_oe_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= 3'd7;
         full_q     <= 1'b0;
         shift_q    <= 8'd0;
         rx_data_q  <= 8'd0;
         sda_oe_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         sda_oe_q   <= sda_oe_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;
   assign rw       = rw_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master tasks, queue scoreboard for rx/tx events.
module tb_i2c_slave;
   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, rx_valid, tx_req, busy, rw;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;

   int         checks = 0;
   int         errors = 0;
   int         tx_pulses = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];
   logic       rxv_prev = 1'b0, txr_prev = 1'b0, oe_prev = 1'b0;
   logic [7:0] tv[4];

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_m),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .rw       (rw)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic qwait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every rx_valid / tx_req pulse.
   always @(negedge clk) begin
      if (rx_valid && rxv_prev) check("rx_valid_width", {31'd0, rxv_prev}, 32'd0);
      else if (rx_valid && exp_rx.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'h100);
      else if (rx_valid) check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      if (tx_req && !txr_prev) tx_pulses++;
      if (tx_req && txr_prev) check("tx_req_width", {31'd0, txr_prev}, 32'd0);
      else if (tx_req && exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'h100);
      else if (tx_req) check("tx_req_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      if (!reset && sda_oe !== oe_prev) check("oe_change_scl_high", {31'd0, scl_m}, 32'd0);
      rxv_prev <= rx_valid;
      txr_prev <= tx_req;
      oe_prev  <= sda_oe;
   end

   task automatic bus_bit(input logic b, output logic seen, output logic oe_seen);
      qwait(Q); sda_m = b; qwait(Q); scl_m = 1'b1;
      qwait(Q); seen = sda_line; oe_seen = sda_oe;
      qwait(Q); scl_m = 1'b0;
   endtask

   // Works both from an idle bus and as a repeated START.
   task automatic start_cond();
      qwait(Q); sda_m = 1'b1; qwait(Q); scl_m = 1'b1;
      qwait(Q); sda_m = 1'b0; qwait(Q); scl_m = 1'b0;
   endtask

   task automatic stop_cond();
      qwait(Q); sda_m = 1'b0; qwait(Q); scl_m = 1'b1;
      qwait(Q); sda_m = 1'b1; qwait(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic s, o, any_oe, exp_oe;
      any_oe = 1'b0;
      exp_oe = ~exp_ack;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(b[i], s, o);
         any_oe = any_oe | o;
      end
      check({tag, "_oe_data"}, {31'd0, any_oe}, 32'd0);
      bus_bit(1'b1, s, o);
      check({tag, "_ack"}, {31'd0, s}, {31'd0, exp_ack});
      check({tag, "_ack_oe"}, {31'd0, o}, {31'd0, exp_oe});
   endtask

   task automatic read_byte(input logic [7:0] exp, input logic mack, input logic [7:0] next_tx,
                            input string tag);
      logic [7:0] got;
      logic s, o;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s, o);
         got[i] = s;
         if (i == 7) tx_data = next_tx;
      end
      bus_bit(mack, s, o);
      check({tag, "_data"}, {24'd0, got}, {24'd0, exp});
   endtask

   // Reference model: address hit is a plain compare; writes ACK and deliver bytes.
   task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] v[4], input bit do_stop);
      logic hit;
      hit = (a == 7'h50);
      start_cond();
      write_byte({a, 1'b0}, hit ? 1'b0 : 1'b1, "wr_addr");
      check("wr_busy", {31'd0, busy}, {31'd0, hit});
      for (int k = 0; k < n; k++) begin
         if (hit) exp_rx.push_back(v[k]);
         write_byte(v[k], hit ? 1'b0 : 1'b1, "wr_data");
      end
      check("wr_busy_end", {31'd0, busy}, {31'd0, hit});
      if (do_stop) begin
         stop_cond();
         qwait(4);
         check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic do_read(input logic [6:0] a, input int n, input logic [7:0] v[4]);
      logic hit, last;
      hit = (a == 7'h50);
      tx_data = v[0];
      start_cond();
      if (hit) exp_tx.push_back(v[0]);
      write_byte({a, 1'b1}, hit ? 1'b0 : 1'b1, "rd_addr");
      check("rd_rw", {31'd0, rw & busy}, {31'd0, hit});
      for (int k = 0; k < n; k++) begin
         last = (k == n - 1);
         if (hit && !last) exp_tx.push_back(v[k+1]);
         read_byte(hit ? v[k] : 8'hFF, last ? 1'b1 : 1'b0, v[k+1], "rd");
      end
      qwait(4);
      check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
      check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
      stop_cond();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int t0;
      logic s, o;
      qwait(3);
      check("reset_outputs", {19'd0, sda_oe, rx_data, rx_valid, tx_req, busy, rw}, 32'd0);
      reset = 1'b0;
      qwait(5);

      tv = '{8'hA5, 8'h3C, 8'h00, 8'h00};
      do_write(7'h50, 2, tv, 1'b1);
      tv = '{8'h5A, 8'h00, 8'h00, 8'h00};
      do_write(7'h51, 1, tv, 1'b1);

      t0 = tx_pulses;
      tv = '{8'hC3, 8'h81, 8'h00, 8'h00};
      do_read(7'h50, 2, tv);
      qwait(4);
      check("tx_req_count", tx_pulses - t0, 32'd2);

      tv = '{8'h01, 8'h00, 8'h00, 8'h00};
      do_write(7'h50, 1, tv, 1'b0);
      tv = '{8'h96, 8'h00, 8'h00, 8'h00};
      do_read(7'h50, 1, tv);
      check("rstart_rx_data", {24'd0, rx_data}, 32'h01);

      start_cond();
      bus_bit(1'b1, s, o); bus_bit(1'b0, s, o); bus_bit(1'b1, s, o); bus_bit(1'b0, s, o);
      reset = 1'b1;
      #1;
      check("reset_mid_byte", {19'd0, sda_oe, rx_data, rx_valid, tx_req, busy, rw}, 32'd0);
      qwait(2);
      reset = 1'b0;
      sda_m = 1'b1; qwait(Q); scl_m = 1'b1; qwait(Q);
      tv = '{8'h77, 8'h00, 8'h00, 8'h00};
      do_write(7'h50, 1, tv, 1'b1);
      check("post_reset_rx_data", {24'd0, rx_data}, 32'h77);

      start_cond();
      write_byte(8'hA0, 1'b0, "mid_addr");
      bus_bit(1'b1, s, o); bus_bit(1'b0, s, o); bus_bit(1'b1, s, o);
      stop_cond();
      qwait(4);
      check("mid_stop_busy", {31'd0, busy}, 32'd0);
      check("mid_stop_oe", {31'd0, sda_oe}, 32'd0);

      for (int r = 0; r < 10; r++) begin
         logic [6:0] a;
         int n;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
         n = $urandom_range(1, 3);
         for (int k = 0; k < 4; k++) tv[k] = 8'($urandom);
         if ($urandom_range(0, 1) == 0) do_write(a, n, tv, 1'b1);
         else do_read(a, n, tv);
      end

      qwait(10);
      check("rx_queue_drained", exp_rx.size(), 32'd0);
      check("tx_queue_drained", exp_tx.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the codebase's I2C master. Receives START, a 7-bit address plus R/W, and data bytes; drives ACK and read data on SDA.
- Open-drain SDA only: the block never drives SDA high. SCL is input only (no clock stretching).
- SCL and SDA are oversampled on the system clock `clk`. Sits between the board I2C pins (external tri-state buffer) and user logic that consumes and produces bytes.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer depth for scl_in/sda_in (min 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL pin level.
- sda_in  input  1  SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release (high-Z).
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
- tx_req  output  1  one-cycle pulse; tx_data is latched this cycle.
- busy  output  1  1 from an addressed START until STOP or NACK.
- rw  output  1  R/W bit of the current transfer (1 = read).

Behaviour:
- Reset, asynchronous and active-high. All outputs go to 0: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, rw=0. State goes to IDLE and the bit counter goes to 7. Synchronizer flops reset to 1.
- Synchronizers: scl_s and sda_s are the synchronized inputs; prev copies are held one cycle.
  - scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
  - START = sda_s falls while scl_s=1 and scl_p=1.
  - STOP = sda_s rises while scl_s=1 and scl_p=1.
- Event priority: START and STOP outrank the state machine in every state.
  - START (including repeated START): go to ADDR, counter=7, sda_oe=0.
  - STOP: go to IDLE, sda_oe=0, busy=0.
- Data sampling: done on scl_rise only. sda_oe changes on scl_fall only; it never changes while scl_s=1.
- States:
  - IDLE: wait for START.
  - ADDR: shift sda_s in MSB first on each scl_rise; the 8th bit is R/W.
    - On the scl_fall after bit 0: if addr == SLAVE_ADDR, set rw, set busy=1, set sda_oe=1, go to ADDR_ACK.
    - Otherwise go to IGNORE with sda_oe=0.
  - ADDR_ACK: on the next scl_fall:
    - rw=0: sda_oe=0, go to WR_DATA.
    - rw=1: latch tx_data, pulse tx_req, set sda_oe=~tx_data[7], go to RD_DATA.
  - WR_DATA: shift in 8 bits on scl_rise. On the scl_fall after bit 0: rx_data <= byte, pulse rx_valid, sda_oe=1, go to WR_ACK.
  - WR_ACK: on scl_fall, sda_oe=0, counter=7, go to WR_DATA.
  - RD_DATA: on each scl_fall, present the next bit: sda_oe = ~shift[bit]. After bit 0 is clocked (its scl_fall), sda_oe=0 and go to RD_ACK.
  - RD_ACK: sample the master's ACK on scl_rise.
    - sda_s=0: on the following scl_fall, latch tx_data, pulse tx_req, drive bit 7, go to RD_DATA.
    - sda_s=1 (NACK): go to IGNORE, busy=0.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Latency:
  - rx_valid fires 3 clk cycles after the synchronized 8th SCL falling edge is seen (synchronizer + edge detect). It is exactly one cycle wide per byte.
  - tx_req fires exactly once per read byte, before that byte's MSB is driven.
- General call (address 0) is not supported; it is ignored like any non-matching address.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - RW_READ=1 and RW_WRITE=0;
  - ACK=0 and NACK=1.
- One natural sub-module: i2c_line_sync. It synchronizes SCL and SDA and outputs scl_s, sda_s, scl_rise, scl_fall, start_det and stop_det. It is reusable by a future master revision.

Test Plan:
- Write 0x50+W, then data 0xA5 and 0x3C, then STOP. Required: sda_oe=1 during all three 9th clocks; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy=1 then 0 after STOP.
- Address 0x51+W, then one byte. Required: sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Read 0x50+R with tx_data=0xC3, master ACK, then tx_data=0x81, master NACK. Required: SDA carries 1100_0011 then 1000_0001 MSB first; exactly 2 tx_req pulses; sda_oe=0 after the NACK; busy=0.
- Repeated START: write 0x50+W and 0x01, then repeated START, then 0x50+R. Required: rx_data=0x01; a fresh address phase; rw=1; read data is driven.
- Assert reset for 2 cycles mid-byte (after 4 address bits). Required: all outputs 0 immediately. The following full 0x50+W, 0x77 transfer completes with rx_data=0x77.
- STOP injected mid-data-byte after 3 bits. Required: state returns to IDLE, no rx_valid, sda_oe=0, busy=0.
